// File: rtl/int_seq_pkg.sv
// Shared types and constants for the interrupt sequencer.
// State codes and drain-length limit.
package int_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_VECTOR = 3'd2,
        ST_ISR    = 3'd3,
        ST_RETURN = 3'd4
    } state_t;

    localparam int DRAIN_MAX = 7;

endpackage

// File: rtl/int_seq_save.sv
// n-bit holding register with load enable and synchronous clear.
// Used for the saved return PC and the latched vector.
module int_seq_save #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ld,
    input  logic [n-1:0] d,
    output logic [n-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/int_seq.sv
// Interrupt sequencer: drain, redirect to vector, run ISR, return.
// Single-level; interrupts stay disabled until the return redirect.
module int_seq
    import int_seq_pkg::*;
#(
    parameter int n     = 8,
    parameter int DRAIN = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         i_pend,
    input  logic [n-1:0] vec_addr,
    input  logic [n-1:0] pc_cur,
    input  logic         reti,
    output logic         stall,
    output logic         flush,
    output logic         pc_load,
    output logic [n-1:0] pc_next,
    output logic         clr_ien,
    output logic         set_ien,
    output logic         in_isr
);

    if (DRAIN < 1 || DRAIN > DRAIN_MAX) begin : g_bad_drain
        $error("int_seq: DRAIN out of range");
    end

    localparam logic [2:0] CNT_LAST = 3'(DRAIN - 1);

    state_t       state;
    state_t       state_nx;
    logic [2:0]   cnt;
    logic [n-1:0] ret_pc;
    logic [n-1:0] vec_reg;
    logic         ret_ld;
    logic         vec_ld;

    assign ret_ld = (state == ST_IDLE) && i_pend;
    assign vec_ld = (state == ST_DRAIN);

    int_seq_save #(.n(n)) u_ret (
        .clk (clk),
        .clr (clr),
        .ld  (ret_ld),
        .d   (pc_cur),
        .q   (ret_pc)
    );

    // Reloaded every drain cycle so the final RAM read wins.
    int_seq_save #(.n(n)) u_vec (
        .clk (clk),
        .clr (clr),
        .ld  (vec_ld),
        .d   (vec_addr),
        .q   (vec_reg)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (clr || ret_ld) begin
            cnt <= 3'd0;
        end else if (state == ST_DRAIN) begin
            cnt <= cnt + 3'd1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:   if (i_pend) state_nx = ST_DRAIN;
            ST_DRAIN:  if (cnt == CNT_LAST) state_nx = ST_VECTOR;
            ST_VECTOR: state_nx = ST_ISR;
            ST_ISR:    if (reti) state_nx = ST_RETURN;
            ST_RETURN: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        stall   = 1'b0;
        flush   = 1'b0;
        pc_load = 1'b0;
        pc_next = '0;
        clr_ien = 1'b0;
        set_ien = 1'b0;
        in_isr  = 1'b0;
        unique case (state)
            ST_DRAIN: begin
                stall   = 1'b1;
                clr_ien = (cnt == 3'd0);
            end
            ST_VECTOR: begin
                pc_load = 1'b1;
                pc_next = vec_reg;
                flush   = 1'b1;
            end
            ST_ISR: begin
                in_isr = 1'b1;
            end
            ST_RETURN: begin
                pc_load = 1'b1;
                pc_next = ret_pc;
                flush   = 1'b1;
                set_ien = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_int_seq.sv
// Directed bench for int_seq (n=8, DRAIN=2).
// Outputs are checked 1 time unit after each rising edge.
module tb_int_seq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         clr;
    logic         i_pend;
    logic [N-1:0] vec_addr;
    logic [N-1:0] pc_cur;
    logic         reti;
    logic         stall;
    logic         flush;
    logic         pc_load;
    logic [N-1:0] pc_next;
    logic         clr_ien;
    logic         set_ien;
    logic         in_isr;

    int n_cmp = 0;
    int n_bad = 0;

    int_seq #(.n(N), .DRAIN(2)) dut (
        .clk      (clk),
        .clr      (clr),
        .i_pend   (i_pend),
        .vec_addr (vec_addr),
        .pc_cur   (pc_cur),
        .reti     (reti),
        .stall    (stall),
        .flush    (flush),
        .pc_load  (pc_load),
        .pc_next  (pc_next),
        .clr_ien  (clr_ien),
        .set_ien  (set_ien),
        .in_isr   (in_isr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected fields: stall flush pc_load pc_next clr_ien set_ien in_isr
    task automatic chk(
        input string        tag,
        input logic         e_st,
        input logic         e_fl,
        input logic         e_pl,
        input logic [N-1:0] e_pn,
        input logic         e_ci,
        input logic         e_si,
        input logic         e_ii
    );
        logic [N+5:0] obs;
        logic [N+5:0] exp_v;
        obs   = {stall, flush, pc_load, pc_next, clr_ien, set_ien, in_isr};
        exp_v = {e_st, e_fl, e_pl, e_pn, e_ci, e_si, e_ii};
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp_v);
        end
    endtask

    initial begin
        clr      = 1'b1;
        i_pend   = 1'b1;
        vec_addr = 8'h00;
        pc_cur   = 8'h12;
        reti     = 1'b0;

        // reset with i_pend held high
        tick(); chk("rst_c1", 0, 0, 0, 8'h00, 0, 0, 0);
        tick(); chk("rst_c2", 0, 0, 0, 8'h00, 0, 0, 0);
        clr = 1'b0;
        tick(); chk("rel_drain0", 1, 0, 0, 8'h00, 1, 0, 0);
        i_pend   = 1'b0;
        vec_addr = 8'h55;
        tick(); chk("rel_drain1", 1, 0, 0, 8'h00, 0, 0, 0);
        tick(); chk("rel_vector", 0, 1, 1, 8'h55, 0, 0, 0);
        tick(); chk("rel_isr", 0, 0, 0, 8'h00, 0, 0, 1);
        reti = 1'b1;
        tick(); chk("rel_return", 0, 1, 1, 8'h12, 0, 1, 0);
        reti = 1'b0;
        tick(); chk("rel_idle", 0, 0, 0, 8'h00, 0, 0, 0);

        // basic service; vec_addr settles late, i_pend dropped mid-drain
        pc_cur   = 8'h34;
        vec_addr = 8'h00;
        i_pend   = 1'b1;
        tick(); chk("bas_drain0", 1, 0, 0, 8'h00, 1, 0, 0);
        i_pend   = 1'b0;
        vec_addr = 8'h11;
        tick(); chk("bas_drain1", 1, 0, 0, 8'h00, 0, 0, 0);
        vec_addr = 8'h80;
        tick(); chk("bas_vector", 0, 1, 1, 8'h80, 0, 0, 0);
        tick(); chk("bas_isr0", 0, 0, 0, 8'h00, 0, 0, 1);
        pc_cur = 8'h99;
        i_pend = 1'b1;
        tick(); chk("isr_pend1", 0, 0, 0, 8'h00, 0, 0, 1);
        i_pend = 1'b0;
        tick(); chk("isr_pend0", 0, 0, 0, 8'h00, 0, 0, 1);
        i_pend = 1'b1;
        tick(); chk("isr_pend1b", 0, 0, 0, 8'h00, 0, 0, 1);
        i_pend = 1'b0;
        reti   = 1'b1;
        tick(); chk("bas_return", 0, 1, 1, 8'h34, 0, 1, 0);
        reti = 1'b0;
        tick(); chk("bas_idle", 0, 0, 0, 8'h00, 0, 0, 0);

        // reti in idle has no effect
        reti = 1'b1;
        tick(); chk("idle_reti0", 0, 0, 0, 8'h00, 0, 0, 0);
        tick(); chk("idle_reti1", 0, 0, 0, 8'h00, 0, 0, 0);
        reti = 1'b0;

        // back-to-back with i_pend held through return
        pc_cur   = 8'h40;
        vec_addr = 8'hA0;
        i_pend   = 1'b1;
        tick(); chk("b2b_drain0", 1, 0, 0, 8'h00, 1, 0, 0);
        tick(); chk("b2b_drain1", 1, 0, 0, 8'h00, 0, 0, 0);
        tick(); chk("b2b_vector", 0, 1, 1, 8'hA0, 0, 0, 0);
        tick(); chk("b2b_isr", 0, 0, 0, 8'h00, 0, 0, 1);
        reti = 1'b1;
        tick(); chk("b2b_return", 0, 1, 1, 8'h40, 0, 1, 0);
        reti   = 1'b0;
        pc_cur = 8'h42;
        tick(); chk("b2b_gap", 0, 0, 0, 8'h00, 0, 0, 0);
        tick(); chk("b2b_drain0b", 1, 0, 0, 8'h00, 1, 0, 0);
        i_pend   = 1'b0;
        vec_addr = 8'hB0;
        tick(); chk("b2b_drain1b", 1, 0, 0, 8'h00, 0, 0, 0);
        tick(); chk("b2b_vectorb", 0, 1, 1, 8'hB0, 0, 0, 0);
        tick(); chk("b2b_isrb", 0, 0, 0, 8'h00, 0, 0, 1);
        reti = 1'b1;
        tick(); chk("b2b_returnb", 0, 1, 1, 8'h42, 0, 1, 0);
        reti = 1'b0;
        tick(); chk("b2b_idleb", 0, 0, 0, 8'h00, 0, 0, 0);

        // clr during drain cycle 1
        pc_cur = 8'h50;
        i_pend = 1'b1;
        tick(); chk("mr_drain0", 1, 0, 0, 8'h00, 1, 0, 0);
        i_pend = 1'b0;
        tick(); chk("mr_drain1", 1, 0, 0, 8'h00, 0, 0, 0);
        clr = 1'b1;
        tick(); chk("mr_clr_d", 0, 0, 0, 8'h00, 0, 0, 0);
        clr = 1'b0;
        tick(); chk("mr_post_d", 0, 0, 0, 8'h00, 0, 0, 0);

        // clr during ISR
        i_pend = 1'b1;
        tick(); chk("mr2_drain0", 1, 0, 0, 8'h00, 1, 0, 0);
        i_pend = 1'b0;
        tick(); chk("mr2_drain1", 1, 0, 0, 8'h00, 0, 0, 0);
        tick(); chk("mr2_vector", 0, 1, 1, 8'hB0, 0, 0, 0);
        tick(); chk("mr2_isr", 0, 0, 0, 8'h00, 0, 0, 1);
        clr = 1'b1;
        tick(); chk("mr2_clr_i", 0, 0, 0, 8'h00, 0, 0, 0);
        clr = 1'b0;
        tick(); chk("mr2_post0", 0, 0, 0, 8'h00, 0, 0, 0);
        tick(); chk("mr2_post1", 0, 0, 0, 8'h00, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
